// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Issues load/store requests to data memory
// over a req/ack handshake, formats store lanes and load data, stalls the
// upstream stages while an access is outstanding and drives the memwb inputs.
// Optional build macro MISALIGN_TRAP_EN adds o_misalign and suppresses
// misaligned halfword/word accesses instead of aligning them down.
module mem_stage #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [31:0]   i_aluo,
  input  logic [31:0]   i_rs2_data,
  input  logic [4:0]    i_rd,
  input  logic [31:0]   i_imm,
  input  logic [2:0]    i_funct3,
  input  logic          i_mem_r,
  input  logic          i_mem_w,
  input  logic          i_mem_t_reg,
  input  logic          i_reg_w,
  input  logic          i_rd_in,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [3:0]    dmem_be,
  output logic [31:0]   dmem_wdata,
  input  logic [31:0]   dmem_rdata,
  input  logic          dmem_ack,
  output logic [31:0]   o_ddata,
  output logic [31:0]   o_aluo,
  output logic [4:0]    o_rd,
  output logic [31:0]   o_imm,
  output logic          o_mem_t_reg,
  output logic          o_reg_w,
  output logic          o_rd_in,
  output logic          o_stall
`ifdef MISALIGN_TRAP_EN
  , output logic        o_misalign
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_nx;

  // latched copy of the request, held from issue through DONE
  logic [31:0] l_aluo, l_rs2, l_imm, l_ddata;
  logic [4:0]  l_rd;
  logic [2:0]  l_f3;
  logic        l_we, l_mem_t_reg, l_reg_w, l_rd_in;

  // request source: live inputs in the IDLE issue cycle, latched copy after
  logic [31:0] s_addr, s_rs2;
  logic [2:0]  s_f3;
  logic        s_we;
  logic        is_mem, misal, issue;

  function automatic logic [31:0] ld_fmt(input logic [31:0] d, input logic [1:0] a,
                                         input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = d[{a, 3'b000} +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'b0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'b0, h};
      default: r = d;                 // W and undefined sizes
    endcase
    return r;
  endfunction

  function automatic logic [3:0] st_be(input logic [1:0] a, input logic [2:0] f3);
    logic [3:0] r;
    case (f3)
      3'b000:  r = 4'b0001 << a;
      3'b001:  r = 4'b0011 << {a[1], 1'b0};
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] st_data(input logic [31:0] d, input logic [2:0] f3);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {4{d[7:0]}};
      3'b001:  r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  assign is_mem = i_valid & (i_mem_r | i_mem_w);

`ifdef MISALIGN_TRAP_EN
  // H/HU need an even address; W (and sizes treated as W) need word alignment
  assign misal = is_mem &
                 ((((i_funct3 == 3'b001) | (i_funct3 == 3'b101)) & i_aluo[0]) |
                  (!(i_funct3 inside {3'b000, 3'b100, 3'b001, 3'b101}) & (i_aluo[1:0] != 2'b00)));
  assign o_misalign = rst_n & (state == IDLE) & misal;
`else
  assign misal = 1'b0;
`endif

  assign issue  = (state == IDLE) & is_mem & !misal;
  assign s_addr = (state == IDLE) ? i_aluo     : l_aluo;
  assign s_rs2  = (state == IDLE) ? i_rs2_data : l_rs2;
  assign s_f3   = (state == IDLE) ? i_funct3   : l_f3;
  assign s_we   = (state == IDLE) ? i_mem_w    : l_we;   // r&w together is a store

  assign dmem_we    = s_we;
  assign dmem_addr  = {s_addr[AW-1:2], 2'b00};
  assign dmem_be    = s_we ? st_be(s_addr[1:0], s_f3) : 4'b1111;
  assign dmem_wdata = st_data(s_rs2, s_f3);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // latch the request on issue, capture formatted load data on ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_aluo <= '0; l_rs2 <= '0; l_imm <= '0; l_ddata <= '0; l_rd <= '0; l_f3 <= '0;
      l_we <= 1'b0; l_mem_t_reg <= 1'b0; l_reg_w <= 1'b0; l_rd_in <= 1'b0;
    end else begin
      if (issue) begin
        l_aluo <= i_aluo; l_rs2 <= i_rs2_data; l_imm <= i_imm; l_rd <= i_rd;
        l_f3 <= i_funct3; l_we <= i_mem_w; l_mem_t_reg <= i_mem_t_reg;
        l_reg_w <= i_reg_w; l_rd_in <= i_rd_in;
      end
      if (dmem_req && dmem_ack)
        l_ddata <= s_we ? 32'h0 : ld_fmt(dmem_rdata, s_addr[1:0], s_f3);
    end
  end

  // next state, handshake and memwb-facing outputs
  always_comb begin
    state_nx    = state;
    dmem_req    = 1'b0;
    o_stall     = 1'b0;
    o_aluo      = i_aluo;
    o_rd        = i_rd;
    o_imm       = i_imm;
    o_rd_in     = i_rd_in;
    o_ddata     = 32'h0;
    o_reg_w     = i_valid & i_reg_w;
    o_mem_t_reg = i_valid & i_mem_t_reg;
    case (state)
      IDLE: begin
        if (is_mem) begin
          o_reg_w     = 1'b0;
          o_mem_t_reg = 1'b0;
          if (!misal) begin
            dmem_req = 1'b1;
            o_stall  = 1'b1;
            state_nx = dmem_ack ? DONE : WAIT;
          end
        end
      end
      WAIT: begin
        dmem_req    = 1'b1;
        o_stall     = 1'b1;
        o_reg_w     = 1'b0;
        o_mem_t_reg = 1'b0;
        if (dmem_ack) state_nx = DONE;
      end
      DONE: begin
        o_aluo      = l_aluo;
        o_rd        = l_rd;
        o_imm       = l_imm;
        o_rd_in     = l_rd_in;
        o_ddata     = l_ddata;
        o_reg_w     = l_reg_w & !l_we;
        o_mem_t_reg = l_mem_t_reg;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // reset drops the handshake and bubbles memwb immediately
    if (!rst_n) begin
      dmem_req    = 1'b0;
      o_stall     = 1'b0;
      o_reg_w     = 1'b0;
      o_mem_t_reg = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage; expected memwb outputs are
// queued at issue and checked by a monitor whenever the stage retires.
module tb_mem_stage;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        i_valid = 0, i_mem_r = 0, i_mem_w = 0, i_mem_t_reg = 0, i_reg_w = 0, i_rd_in = 0;
  logic [31:0] i_aluo = 0, i_rs2_data = 0, i_imm = 0, dmem_rdata = 0;
  logic [4:0]  i_rd = 0;
  logic [2:0]  i_funct3 = 0;
  logic        dmem_ack = 0;
  logic        dmem_req, dmem_we, o_mem_t_reg, o_reg_w, o_rd_in, o_stall;
  logic [31:0] dmem_addr, dmem_wdata, o_ddata, o_aluo, o_imm;
  logic [3:0]  dmem_be;
  logic [4:0]  o_rd;
`ifdef MISALIGN_TRAP_EN
  logic        o_misalign;
`endif

  mem_stage #(.AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_aluo(i_aluo), .i_rs2_data(i_rs2_data),
    .i_rd(i_rd), .i_imm(i_imm), .i_funct3(i_funct3), .i_mem_r(i_mem_r), .i_mem_w(i_mem_w),
    .i_mem_t_reg(i_mem_t_reg), .i_reg_w(i_reg_w), .i_rd_in(i_rd_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .o_ddata(o_ddata), .o_aluo(o_aluo), .o_rd(o_rd), .o_imm(o_imm),
    .o_mem_t_reg(o_mem_t_reg), .o_reg_w(o_reg_w), .o_rd_in(o_rd_in), .o_stall(o_stall)
`ifdef MISALIGN_TRAP_EN
    , .o_misalign(o_misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] aluo, ddata;
    logic [4:0]  rd;
    logic        reg_w, mt, chk_dd;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // monitor: every cycle the stage retires a real slot, compare against the queue head
  always @(negedge clk) begin
    if (rst_n && i_valid && !o_stall) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_retire: aluo %h with empty scoreboard", o_aluo);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wb_aluo", o_aluo, e.aluo);
        chk("wb_rd", {27'b0, o_rd}, {27'b0, e.rd});
        chk("wb_reg_w", {31'b0, o_reg_w}, {31'b0, e.reg_w});
        chk("wb_mem_t_reg", {31'b0, o_mem_t_reg}, {31'b0, e.mt});
        if (e.chk_dd) chk("wb_ddata", o_ddata, e.ddata);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] aluo, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic [2:0] f3, input logic r,
                       input logic w, input logic mt, input logic rw);
    i_valid = v; i_aluo = aluo; i_rs2_data = rs2; i_rd = rd; i_imm = aluo ^ 32'h5A5A_0000;
    i_funct3 = f3; i_mem_r = r; i_mem_w = w; i_mem_t_reg = mt; i_reg_w = rw; i_rd_in = rw;
  endtask

  // issue a memory op, ack after 'waits' WAIT cycles, then expect one DONE cycle
  task automatic run_mem(input logic [31:0] addr, input logic [2:0] f3, input logic r,
                         input logic w, input logic [31:0] rs2, input logic [31:0] rdata,
                         input int waits, input logic [4:0] rd, input logic rw, input logic mt,
                         input logic [3:0] ebe, input logic [31:0] ewd,
                         input logic [31:0] edd, input logic chk_dd, input logic erw);
    exp_t e;
    drive(1'b1, addr, rs2, rd, f3, r, w, mt, rw);
    dmem_rdata = rdata;
    for (int c = 0; c <= waits; c++) begin
      dmem_ack = (c == waits);
      #3;
      chk("req_high", {31'b0, dmem_req}, 32'd1);
      chk("stall_high", {31'b0, o_stall}, 32'd1);
      chk("stall_reg_w", {31'b0, o_reg_w}, 32'd0);
      chk("stall_mem_t_reg", {31'b0, o_mem_t_reg}, 32'd0);
      chk("req_addr", dmem_addr, {addr[31:2], 2'b00});
      chk("req_we", {31'b0, dmem_we}, {31'b0, w});
      chk("req_be", {28'b0, dmem_be}, {28'b0, ebe});
      if (w) chk("req_wdata", dmem_wdata, ewd);
      step();
    end
    dmem_ack = 1'b0;
    e.aluo = addr; e.ddata = edd; e.rd = rd; e.reg_w = erw; e.mt = mt; e.chk_dd = chk_dd;
    q.push_back(e);
    #3;
    chk("done_stall", {31'b0, o_stall}, 32'd0);
    chk("done_req", {31'b0, dmem_req}, 32'd0);
    step();
  endtask

  initial begin
    exp_t e;
    // reset: a pending load on the inputs must not raise a request
    drive(1'b1, 32'h10, 32'h0, 5'd1, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_stall", {31'b0, o_stall}, 32'd0);
    chk("rst_reg_w", {31'b0, o_reg_w}, 32'd0);
    chk("rst_mem_t_reg", {31'b0, o_mem_t_reg}, 32'd0);
    i_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    // ALU pass-through, zero latency
    drive(1'b1, 32'h1234, 32'h0, 5'd7, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    e.aluo = 32'h1234; e.ddata = 32'h0; e.rd = 5'd7; e.reg_w = 1'b1; e.mt = 1'b0; e.chk_dd = 1'b1;
    q.push_back(e);
    #3;
    chk("alu_stall", {31'b0, o_stall}, 32'd0);
    chk("alu_req", {31'b0, dmem_req}, 32'd0);
    step();

    //      addr          f3     r  w  rs2           rdata        wt rd    rw mt  be       wdata         ddata         chk rw
    run_mem(32'h103, 3'b000, 1, 0, 32'h0,        32'h80AABBCC, 3, 5'd2, 1, 1, 4'b1111, 32'h0,        32'hFFFFFF80, 1, 1); // LB
    run_mem(32'h202, 3'b101, 1, 0, 32'h0,        32'h98765432, 0, 5'd3, 1, 1, 4'b1111, 32'h0,        32'h00009876, 1, 1); // LHU
    run_mem(32'h301, 3'b000, 0, 1, 32'h000000EE, 32'h0,        1, 5'd0, 0, 0, 4'b0010, 32'hEEEEEEEE, 32'h0,        0, 0); // SB
    run_mem(32'h302, 3'b001, 0, 1, 32'h1234ABCD, 32'h0,        0, 5'd0, 0, 0, 4'b1100, 32'hABCDABCD, 32'h0,        0, 0); // SH
    run_mem(32'h400, 3'b010, 0, 1, 32'hDEADBEEF, 32'h0,        2, 5'd0, 0, 0, 4'b1111, 32'hDEADBEEF, 32'h0,        0, 0); // SW
    run_mem(32'h500, 3'b001, 1, 0, 32'h0,        32'h12348001, 1, 5'd4, 1, 1, 4'b1111, 32'h0,        32'hFFFF8001, 1, 1); // LH
    run_mem(32'h601, 3'b100, 1, 0, 32'h0,        32'h11229A33, 0, 5'd5, 1, 1, 4'b1111, 32'h0,        32'h0000009A, 1, 1); // LBU
    run_mem(32'h700, 3'b011, 1, 0, 32'h0,        32'hCAFEF00D, 1, 5'd6, 1, 1, 4'b1111, 32'h0,        32'hCAFEF00D, 1, 1); // undef -> W
    run_mem(32'h800, 3'b010, 1, 1, 32'h00000055, 32'h0,        0, 5'd8, 1, 0, 4'b1111, 32'h00000055, 32'h0,        0, 0); // r&w -> store

    // bubble
    drive(1'b0, 32'h999, 32'h0, 5'd9, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    #3;
    chk("bubble_reg_w", {31'b0, o_reg_w}, 32'd0);
    chk("bubble_mem_t_reg", {31'b0, o_mem_t_reg}, 32'd0);
    step();

    // reset mid-WAIT: request drops at once, late ack ignored
    drive(1'b1, 32'h10, 32'h0, 5'd1, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1);
    dmem_ack = 1'b0;
    #3; chk("rw_req_issue", {31'b0, dmem_req}, 32'd1);
    step();
    #3; chk("rw_req_wait", {31'b0, dmem_req}, 32'd1);
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("rw_req_async", {31'b0, dmem_req}, 32'd0);
    chk("rw_stall_async", {31'b0, o_stall}, 32'd0);
    step();
    rst_n = 1'b1; i_valid = 1'b0; dmem_ack = 1'b1;
    #3;
    chk("late_ack_req", {31'b0, dmem_req}, 32'd0);
    chk("late_ack_stall", {31'b0, o_stall}, 32'd0);
    step();
    dmem_ack = 1'b0;
    #3;
    chk("late_ack_reg_w", {31'b0, o_reg_w}, 32'd0);
    step();
    // stage must be back in IDLE: a same-cycle-ack load behaves normally
    run_mem(32'h202, 3'b101, 1, 0, 32'h0, 32'h98765432, 0, 5'd3, 1, 1, 4'b1111, 32'h0, 32'h00009876, 1, 1);

`ifdef MISALIGN_TRAP_EN
    drive(1'b1, 32'h402, 32'h0, 5'd10, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1);
    e.aluo = 32'h402; e.ddata = 32'h0; e.rd = 5'd10; e.reg_w = 1'b0; e.mt = 1'b0; e.chk_dd = 1'b0;
    q.push_back(e);
    #3;
    chk("mis_req", {31'b0, dmem_req}, 32'd0);
    chk("mis_stall", {31'b0, o_stall}, 32'd0);
    chk("mis_flag", {31'b0, o_misalign}, 32'd1);
    step();
    i_valid = 1'b0;
    #3; chk("mis_flag_clear", {31'b0, o_misalign}, 32'd0);
    step();
`endif

    i_valid = 1'b0;
    step();
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
